// File: rtl/hazard_forward_unit_pkg.sv
// Shared pipeline definitions: stage result record, forwarding source codes,
// zero-register id and the saturating counter helper.
package hazard_forward_unit_pkg;

  // Stage records are carried at the pipeline's native operand/register widths.
  localparam int PIPE_DATA_WIDTH   = 32;
  localparam int PIPE_REG_ID_WIDTH = 5;

  localparam logic [PIPE_REG_ID_WIDTH-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    SRC_REGFILE = 2'd0,
    SRC_STAGE   = 2'd1,
    SRC_HELD    = 2'd2,
    SRC_STALL   = 2'd3
  } fwd_src_e;

  typedef struct packed {
    logic [PIPE_REG_ID_WIDTH-1:0] reg_id;
    logic                         ready;
    logic [PIPE_DATA_WIDTH-1:0]   data;
  } stage_result_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hff) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_port.sv
// One source-operand port: youngest-first stage lookup plus the registered
// operand, source code and stall bit held for the instruction in decode.
module forward_port
  import hazard_forward_unit_pkg::*;
#(
  parameter int NUM_STAGES   = 3,
  parameter int DATA_WIDTH   = 32,
  parameter int REG_ID_WIDTH = 5
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             tag_change,
  input  logic                             used,
  input  logic [REG_ID_WIDTH-1:0]          reg_id,
  input  logic [DATA_WIDTH-1:0]            rf_data,
  input  stage_result_t [NUM_STAGES-1:0]   stages,
  output logic [DATA_WIDTH-1:0]            data,
  output logic [1:0]                       source,
  output logic                             stall,
  output logic                             stall_next
);

  logic [PIPE_REG_ID_WIDTH-1:0] reg_id_ext;
  logic                         active;
  logic                         hit;
  logic                         hit_ready;
  logic [DATA_WIDTH-1:0]        hit_data;
  logic                         lookup_stall;
  logic [DATA_WIDTH-1:0]        lookup_data;
  fwd_src_e                     lookup_src;

  logic [DATA_WIDTH-1:0]        data_d;
  fwd_src_e                     src_q, src_d;

  assign reg_id_ext = PIPE_REG_ID_WIDTH'(reg_id);
  assign active     = used && (reg_id_ext != ZERO_REG);

  // Scanning oldest to youngest lets the lowest-index match overwrite the rest.
  always_comb begin
    hit       = 1'b0;
    hit_ready = 1'b0;
    hit_data  = '0;
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      if (stages[s].reg_id == reg_id_ext) begin
        hit       = 1'b1;
        hit_ready = stages[s].ready;
        hit_data  = DATA_WIDTH'(stages[s].data);
      end
    end
  end

  always_comb begin
    lookup_stall = active && hit && !hit_ready;
    lookup_data  = (active && hit && hit_ready) ? hit_data : rf_data;
    lookup_src   = (active && hit && hit_ready) ? SRC_STAGE : SRC_REGFILE;
  end

  // Outputs move only on a new instruction, a stall transition or a flush;
  // a stall exit without a new instruction freezes the operand as "held".
  always_comb begin
    data_d     = data;
    src_d      = src_q;
    stall_next = stall;
    if (flush) begin
      stall_next = 1'b0;
      src_d      = SRC_REGFILE;
    end else if (tag_change) begin
      stall_next = lookup_stall;
      src_d      = lookup_stall ? SRC_STALL : lookup_src;
      data_d     = lookup_data;
    end else if (lookup_stall != stall) begin
      stall_next = lookup_stall;
      if (lookup_stall) begin
        src_d = SRC_STALL;
      end else begin
        src_d  = SRC_HELD;
        data_d = lookup_data;
      end
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      data  <= '0;
      src_q <= SRC_REGFILE;
      stall <= 1'b0;
    end else begin
      data  <= data_d;
      src_q <= src_d;
      stall <= stall_next;
    end
  end

  assign source = src_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding / hazard unit: per-port lookup in forward_port, with the
// instruction tag, stall-length counter and stall watchdog kept here.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int NUM_PORTS        = 2,
  parameter int NUM_STAGES       = 3,
  parameter int DATA_WIDTH       = 32,
  parameter int REG_ID_WIDTH     = 5,
  parameter int MAX_STALL_CYCLES = 15
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [31:0]                      program_counter,
  input  logic [NUM_PORTS-1:0]             port_used,
  input  logic [NUM_PORTS*REG_ID_WIDTH-1:0] port_reg_id,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_rf_data,
  input  logic [NUM_STAGES*REG_ID_WIDTH-1:0] stage_reg_id,
  input  logic [NUM_STAGES-1:0]            stage_data_ready,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0] stage_data,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  forwarded_data,
  output logic [NUM_PORTS*2-1:0]           forward_source,
  output logic                             stall,
  output logic [7:0]                       stall_cycles,
  output logic                             stall_timeout
);

  stage_result_t [NUM_STAGES-1:0] stages;
  logic [31:0]                    tag_q;
  logic                           tag_change;
  logic [NUM_PORTS-1:0]           port_stall;
  logic [NUM_PORTS-1:0]           port_stall_next;
  logic [7:0]                     cycles_d;

  assign tag_change = (program_counter != tag_q);

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    assign stages[s].reg_id = PIPE_REG_ID_WIDTH'(stage_reg_id[s*REG_ID_WIDTH +: REG_ID_WIDTH]);
    assign stages[s].ready  = stage_data_ready[s];
    assign stages[s].data   = PIPE_DATA_WIDTH'(stage_data[s*DATA_WIDTH +: DATA_WIDTH]);
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    forward_port #(
      .NUM_STAGES  (NUM_STAGES),
      .DATA_WIDTH  (DATA_WIDTH),
      .REG_ID_WIDTH(REG_ID_WIDTH)
    ) u_port (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .tag_change(tag_change),
      .used      (port_used[p]),
      .reg_id    (port_reg_id[p*REG_ID_WIDTH +: REG_ID_WIDTH]),
      .rf_data   (port_rf_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .stages    (stages),
      .data      (forwarded_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .source    (forward_source[p*2 +: 2]),
      .stall     (port_stall[p]),
      .stall_next(port_stall_next[p])
    );
  end

  assign stall = |port_stall;

  // The counter measures one instruction's stall; a new instruction restarts it.
  always_comb begin
    cycles_d = 8'd0;
    if (!flush && !tag_change && (|port_stall_next)) begin
      cycles_d = sat_inc8(stall_cycles);
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      tag_q         <= 32'hffff_ffff;
      stall_cycles  <= 8'd0;
      stall_timeout <= 1'b0;
    end else begin
      tag_q         <= flush ? 32'hffff_ffff : program_counter;
      stall_cycles  <= cycles_d;
      stall_timeout <= stall_timeout | (cycles_d == 8'(MAX_STALL_CYCLES));
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: a rule-level reference model compared
// every cycle, plus hand-computed literal expectations per scenario.
module tb_hazard_forward_unit;

  localparam int NP   = 2;
  localparam int NS   = 3;
  localparam int DW   = 32;
  localparam int RW   = 5;
  localparam int MAXC = 4;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  logic flush;
  logic [31:0] pc;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- stimulus arrays and packing ----------------
  logic          u    [NP];
  logic [RW-1:0] rid  [NP];
  logic [DW-1:0] rf   [NP];
  logic [RW-1:0] sid  [NS];
  logic          srdy [NS];
  logic [DW-1:0] sdat [NS];

  logic [NP-1:0]    port_used;
  logic [NP*RW-1:0] port_reg_id;
  logic [NP*DW-1:0] port_rf_data;
  logic [NS*RW-1:0] stage_reg_id;
  logic [NS-1:0]    stage_data_ready;
  logic [NS*DW-1:0] stage_data;

  always_comb begin
    port_used = '0; port_reg_id = '0; port_rf_data = '0;
    stage_reg_id = '0; stage_data_ready = '0; stage_data = '0;
    for (int p = 0; p < NP; p++) begin
      port_used[p] = u[p];
      port_reg_id[p*RW +: RW] = rid[p];
      port_rf_data[p*DW +: DW] = rf[p];
    end
    for (int s = 0; s < NS; s++) begin
      stage_reg_id[s*RW +: RW] = sid[s];
      stage_data_ready[s] = srdy[s];
      stage_data[s*DW +: DW] = sdat[s];
    end
  end

  logic [NP*DW-1:0] forwarded_data;
  logic [NP*2-1:0]  forward_source;
  logic             stall;
  logic [7:0]       stall_cycles;
  logic             stall_timeout;

  hazard_forward_unit #(
    .NUM_PORTS(NP), .NUM_STAGES(NS), .DATA_WIDTH(DW),
    .REG_ID_WIDTH(RW), .MAX_STALL_CYCLES(MAXC)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush), .program_counter(pc),
    .port_used(port_used), .port_reg_id(port_reg_id), .port_rf_data(port_rf_data),
    .stage_reg_id(stage_reg_id), .stage_data_ready(stage_data_ready), .stage_data(stage_data),
    .forwarded_data(forwarded_data), .forward_source(forward_source),
    .stall(stall), .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dat(input int p);
    return forwarded_data[p*DW +: DW];
  endfunction

  function automatic logic [1:0] src(input int p);
    return forward_source[p*2 +: 2];
  endfunction

  // ---------------- reference model ----------------
  logic [DW-1:0] m_data [NP];
  int            m_src  [NP];
  bit            m_st   [NP];
  logic [31:0]   m_tag;
  int            m_cnt;
  bit            m_to;
  bit            cmp_en = 0;

  initial begin
    for (int p = 0; p < NP; p++) begin m_data[p] = '0; m_src[p] = 0; m_st[p] = 0; end
    m_tag = '1; m_cnt = 0; m_to = 0;
  end

  // What a port would see right now: first matching stage wins, ready -> forward,
  // not ready -> stall, no match or no request -> register file.
  function automatic void lookup(input int p, output bit st, output int sr, output logic [DW-1:0] d);
    st = 0; sr = 0; d = rf[p];
    if (u[p] && rid[p] != 0) begin
      for (int s = 0; s < NS; s++) begin
        if (sid[s] == rid[p]) begin
          if (srdy[s]) begin sr = 1; d = sdat[s]; end
          else begin st = 1; sr = 3; end
          break;
        end
      end
    end
  endfunction

  always @(negedge clock) begin
    bit            ls;
    int            lsrc;
    logic [DW-1:0] ld;
    bit            new_instr;
    bit            any;
    if (reset) begin
      for (int p = 0; p < NP; p++) begin m_data[p] = '0; m_src[p] = 0; m_st[p] = 0; end
      m_tag = '1; m_cnt = 0; m_to = 0;
    end else begin
      new_instr = (pc != m_tag);
      any = 0;
      for (int p = 0; p < NP; p++) begin
        lookup(p, ls, lsrc, ld);
        if (flush) begin
          m_st[p] = 0; m_src[p] = 0;
        end else if (new_instr) begin
          m_st[p] = ls; m_src[p] = lsrc; m_data[p] = ld;
        end else if (ls && !m_st[p]) begin
          m_st[p] = 1; m_src[p] = 3;
        end else if (!ls && m_st[p]) begin
          m_st[p] = 0; m_src[p] = 2; m_data[p] = ld;
        end
        any = any | m_st[p];
      end
      if (flush || new_instr || !any) m_cnt = 0;
      else m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      if (m_cnt == MAXC) m_to = 1;
      m_tag = flush ? 32'hffff_ffff : pc;
    end
  end

  // Compare process: outputs are stable at the rising edge, half a cycle after update.
  always @(posedge clock) begin
    if (cmp_en) begin
      bit any_st;
      any_st = 0;
      for (int p = 0; p < NP; p++) begin
        any_st = any_st | m_st[p];
        check($sformatf("model src%0d", p), 64'(src(p)), 64'(m_src[p]));
        if (m_src[p] != 3) check($sformatf("model data%0d", p), 64'(dat(p)), 64'(m_data[p]));
      end
      check("model stall", 64'(stall), 64'(any_st));
      check("model cycles", 64'(stall_cycles), 64'(m_cnt));
      check("model timeout", 64'(stall_timeout), 64'(m_to));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_stages();
    for (int s = 0; s < NS; s++) begin sid[s] = '0; srdy[s] = 1'b0; sdat[s] = '0; end
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    reset = 1'b1; flush = 1'b0; pc = 32'h0;
    for (int p = 0; p < NP; p++) begin u[p] = 1'b0; rid[p] = '0; rf[p] = '0; end
    clear_stages();
    step(); step();
    cmp_en = 1;
    check("rst stall", 64'(stall), 64'd0);
    check("rst cycles", 64'(stall_cycles), 64'd0);
    check("rst timeout", 64'(stall_timeout), 64'd0);
    check("rst data0", 64'(dat(0)), 64'd0);
    check("rst src0", 64'(src(0)), 64'd0);
    reset = 1'b0;

    // stage1 forwards r5
    pc = 32'h100; u[0] = 1; rid[0] = 5; rf[0] = 32'hdead; rf[1] = 32'h55;
    sid[1] = 5; srdy[1] = 1; sdat[1] = 32'h1234;
    step();
    check("hit data0", 64'(dat(0)), 64'h1234);
    check("hit src0", 64'(src(0)), 64'd1);
    check("hit stall", 64'(stall), 64'd0);
    check("unused data1", 64'(dat(1)), 64'h55);
    check("unused src1", 64'(src(1)), 64'd0);

    // youngest not-ready stage wins over older ready one
    pc = 32'h104; clear_stages();
    sid[0] = 5; srdy[0] = 0; sid[2] = 5; srdy[2] = 1; sdat[2] = 32'haa;
    step();
    check("young stall", 64'(stall), 64'd1);
    check("young src0", 64'(src(0)), 64'd3);

    // load-use stall, producer retires to regfile mid-stall
    pc = 32'h108; rid[0] = 7; rf[0] = 32'h11; clear_stages(); sid[0] = 7;
    step();
    check("lw stall", 64'(stall), 64'd1);
    check("lw cycles a", 64'(stall_cycles), 64'd0);
    step();
    check("lw cycles b", 64'(stall_cycles), 64'd1);
    clear_stages(); rf[0] = 32'h77;
    step();
    check("lw release stall", 64'(stall), 64'd0);
    check("lw held src0", 64'(src(0)), 64'd2);
    check("lw held data0", 64'(dat(0)), 64'h77);
    check("lw cycles c", 64'(stall_cycles), 64'd0);
    rf[0] = 32'h99; sid[1] = 7; srdy[1] = 1; sdat[1] = 32'h55;
    step();
    check("lw keep data0", 64'(dat(0)), 64'h77);
    check("lw keep src0", 64'(src(0)), 64'd2);

    // port0 stalls on r3 while port1 forwards r4
    pc = 32'h10c; clear_stages(); rid[0] = 3; sid[0] = 3;
    u[1] = 1; rid[1] = 4; rf[1] = 32'h0; sid[1] = 4; srdy[1] = 1; sdat[1] = 32'h9;
    step();
    check("mix stall", 64'(stall), 64'd1);
    check("mix src1", 64'(src(1)), 64'd1);
    check("mix data1", 64'(dat(1)), 64'h9);
    sdat[1] = 32'h123;
    step();
    check("mix hold data1", 64'(dat(1)), 64'h9);
    check("mix cycles", 64'(stall_cycles), 64'd1);

    // watchdog at MAX_STALL_CYCLES=4
    pc = 32'h110; clear_stages(); u[1] = 0; rid[0] = 6; sid[2] = 6;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("wd cycles %0d", i), 64'(stall_cycles), 64'(i));
      check($sformatf("wd timeout %0d", i), 64'(stall_timeout), (i >= 4) ? 64'd1 : 64'd0);
    end
    sid[2] = 0;
    step();
    check("wd release stall", 64'(stall), 64'd0);
    check("wd sticky a", 64'(stall_timeout), 64'd1);
    pc = 32'h114;
    step();
    check("wd sticky b", 64'(stall_timeout), 64'd1);

    // saturation of the stall counter
    pc = 32'h118; sid[2] = 6;
    repeat (300) step();
    check("sat cycles", 64'(stall_cycles), 64'd255);

    // new instruction on the same edge the stall clears: fresh lookup
    pc = 32'h11c; sid[2] = 0; rf[0] = 32'h42;
    step();
    check("tc src0", 64'(src(0)), 64'd0);
    check("tc data0", 64'(dat(0)), 64'h42);
    check("tc stall", 64'(stall), 64'd0);

    // zero register and unused port never stall
    pc = 32'h120; clear_stages(); rid[0] = 0; rf[0] = 32'h31;
    step();
    check("r0 stall", 64'(stall), 64'd0);
    check("r0 data0", 64'(dat(0)), 64'h31);
    pc = 32'h124; u[0] = 0; rid[0] = 5; sid[0] = 5; rf[0] = 32'h32;
    step();
    check("unused stall", 64'(stall), 64'd0);
    check("unused data0", 64'(dat(0)), 64'h32);
    pc = 32'h128; u[0] = 1; srdy[0] = 1; sdat[0] = 32'hb0; sid[2] = 5; srdy[2] = 0;
    step();
    check("young ready data0", 64'(dat(0)), 64'hb0);
    check("young ready stall", 64'(stall), 64'd0);

    // flush during stall, then reset during stall
    pc = 32'h130; clear_stages(); rid[0] = 6; sid[0] = 6;
    step(); step();
    check("fl pre cycles", 64'(stall_cycles), 64'd1);
    flush = 1'b1;
    step();
    check("fl stall", 64'(stall), 64'd0);
    check("fl cycles", 64'(stall_cycles), 64'd0);
    check("fl src0", 64'(src(0)), 64'd0);
    check("fl src1", 64'(src(1)), 64'd0);
    check("fl timeout", 64'(stall_timeout), 64'd1);
    flush = 1'b0;
    step();
    check("fl restall", 64'(stall), 64'd1);
    check("fl restall src0", 64'(src(0)), 64'd3);
    step();
    reset = 1'b1; flush = 1'b1;
    step();
    check("rs stall", 64'(stall), 64'd0);
    check("rs cycles", 64'(stall_cycles), 64'd0);
    check("rs timeout", 64'(stall_timeout), 64'd0);
    check("rs data0", 64'(dat(0)), 64'd0);
    check("rs src0", 64'(src(0)), 64'd0);
    reset = 1'b0; flush = 1'b0;
    step();
    check("post rs stall", 64'(stall), 64'd1);
    @(posedge clock);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
